// File: rtl/clk_rate_decoder.sv
`default_nettype none
// ============================================================================
// Module   : clk_rate_decoder
// Brief    : Measures the period of the slow sec_clk tick in clk cycles,
//            classifies it as FIFTH/SIXTH/FOURTH and locks after LOCK_N
//            consistent periods. Optional macro RATE_TIMEOUT_EN adds a
//            stalled-tick timeout.
// Revision : 1.0 - initial release
// ============================================================================
module clk_rate_decoder #(
    parameter int CNT_W      = 32,
    parameter int PER_FOURTH = 250000000,
    parameter int PER_FIFTH  = 200000000,
    parameter int PER_SIXTH  = 166666667,
    parameter int TOL        = 16,
    parameter int LOCK_N     = 3,
    parameter int TIMEOUT    = 500000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sec_clk,
    output logic [1:0]       rate_code,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             err
);

    localparam logic [1:0] c_code_fifth  = 2'b00;
    localparam logic [1:0] c_code_sixth  = 2'b01;
    localparam logic [1:0] c_code_fourth = 2'b11;

    localparam logic [1:0] c_st_idle    = 2'b00;
    localparam logic [1:0] c_st_measure = 2'b01;
    localparam logic [1:0] c_st_locked  = 2'b10;

    localparam int                  c_mcnt_w  = $clog2(LOCK_N + 1);
    localparam logic [c_mcnt_w-1:0] c_lock_n  = c_mcnt_w'(LOCK_N);
    localparam logic [CNT_W-1:0]    c_timeout = CNT_W'(TIMEOUT);

`ifdef RATE_TIMEOUT_EN
    localparam logic c_timeout_en = 1'b1;
`else
    localparam logic c_timeout_en = 1'b0;
`endif

    logic                r_sync1, r_sync2, r_sync3, r_edge;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_state;
    logic [c_mcnt_w-1:0] r_mcnt;
    logic [1:0]          r_cand;
    logic [1:0]          r_rate_code;
    logic [CNT_W-1:0]    r_period;
    logic                r_period_valid, r_locked, r_err;

    logic [CNT_W-1:0]    w_meas;
    logic                w_match, w_same, w_timeout;
    logic [1:0]          w_code;
    logic [c_mcnt_w-1:0] w_mcnt_nxt;

    function automatic logic f_in_win(input logic [CNT_W-1:0] meas, input int per);
        logic [CNT_W+1:0] v, lo, hi;
        v  = {2'b00, meas};
        lo = (per > TOL) ? (CNT_W+2)'(per - TOL) : '0;
        hi = (CNT_W+2)'(per + TOL);
        return (v >= lo) && (v <= hi);
    endfunction

    // Two synchronizer flops plus a history flop; edge flag registered once more.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_edge  <= 1'b0;
        end else begin
            r_sync1 <= sec_clk;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_edge  <= r_sync2 & ~r_sync3;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_edge) begin
            r_cnt <= '0;
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A saturated counter yields an all-ones period, which never classifies.
    assign w_meas = (r_cnt == '1) ? '1 : r_cnt + 1'b1;

    always_comb begin
        w_match = 1'b1;
        w_code  = c_code_fifth;
        if (w_meas == '1) begin
            w_match = 1'b0;
        end else if (f_in_win(w_meas, PER_FIFTH)) begin
            w_code = c_code_fifth;
        end else if (f_in_win(w_meas, PER_SIXTH)) begin
            w_code = c_code_sixth;
        end else if (f_in_win(w_meas, PER_FOURTH)) begin
            w_code = c_code_fourth;
        end else begin
            w_match = 1'b0;
        end
    end

    assign w_same     = w_match && (w_code == r_cand);
    assign w_mcnt_nxt = !w_match ? '0 :
                        !w_same  ? c_mcnt_w'(1) :
                        (r_mcnt == c_lock_n) ? r_mcnt : r_mcnt + 1'b1;
    assign w_timeout  = c_timeout_en && !r_edge && (r_state != c_st_idle) &&
                        (r_cnt == c_timeout);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= c_st_idle;
            r_mcnt         <= '0;
            r_cand         <= c_code_fifth;
            r_rate_code    <= c_code_fifth;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_period_valid <= 1'b0;
            r_err          <= 1'b0;
            if (w_timeout) begin
                r_state  <= c_st_idle;
                r_locked <= 1'b0;
                r_mcnt   <= '0;
                r_err    <= 1'b1;
            end else if (r_edge) begin
                if (r_state == c_st_idle) begin
                    r_state <= c_st_measure;
                end else begin
                    r_period       <= w_meas;
                    r_period_valid <= 1'b1;
                    r_err          <= !w_match;
                    r_mcnt         <= w_mcnt_nxt;
                    if (w_match) begin
                        r_cand <= w_code;
                    end
                    if (r_state == c_st_locked) begin
                        if (!w_same) begin
                            r_state  <= c_st_measure;
                            r_locked <= 1'b0;
                        end
                    end else if (w_mcnt_nxt == c_lock_n) begin
                        r_state     <= c_st_locked;
                        r_locked    <= 1'b1;
                        r_rate_code <= w_code;
                    end
                end
            end
        end
    end

    assign rate_code    = r_rate_code;
    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign locked       = r_locked;
    assign err          = r_err;

endmodule
`default_nettype wire
